// File: rtl/rtl_kernel_wizard_0_example_axi_write_master.sv
// AXI4 write master: turns an AXI4-Stream into fixed-size INCR bursts and pulses done when all B's return.
// Optional macro WR_ERR_CHECK_EN adds m_axi_bresp and a sticky ctrl_error flag.
module rtl_kernel_wizard_0_example_axi_write_master #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
   parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
   parameter int unsigned C_BURST_LEN        = 16,
   parameter int unsigned C_MAX_OUTSTANDING  = 16
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic                              ctrl_start,
   output logic                              ctrl_done,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_xfer_size_in_bytes,
`ifdef WR_ERR_CHECK_EN
   output logic                              ctrl_error,
   input  logic [1:0]                        m_axi_bresp,
`endif
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                        m_axi_awlen,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wlast,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axis_tdata
);

   localparam int unsigned BytesPerBeat = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned LogBpb       = $clog2(BytesPerBeat);
   localparam int unsigned BeatW        = C_XFER_SIZE_WIDTH;
   localparam int unsigned OutW         = $clog2(C_MAX_OUTSTANDING + 1);
   localparam int unsigned CntW         = $clog2(C_BURST_LEN + 1);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AddrMask =
      ~(C_M_AXI_ADDR_WIDTH'(BytesPerBeat - 1));

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                          r_state, w_state_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_nxt;
   logic [BeatW-1:0]                r_aw_beats_left, w_aw_beats_left_nxt;
   logic [BeatW-1:0]                r_w_beats_left, w_w_beats_left_nxt;
   logic [BeatW-1:0]                r_aw_issued, w_aw_issued_nxt;
   logic [BeatW-1:0]                r_w_done, w_w_done_nxt;
   logic [CntW-1:0]                 r_w_beat_cnt, w_w_beat_cnt_nxt;
   logic [OutW-1:0]                 r_outstanding, w_outstanding_nxt;
   logic                            r_done, w_done_nxt;
   logic                            r_bready;
`ifdef WR_ERR_CHECK_EN
   logic                            r_error, w_error_nxt;
`endif

   logic                            w_run;
   logic                            w_awvalid;
   logic [7:0]                      w_awlen;
   logic [8:0]                      w_awbeats;
   logic                            w_permit;
   logic                            w_wlast;
   logic                            w_aw_hs;
   logic                            w_w_hs;
   logic                            w_b_hs;
   logic [BeatW-1:0]                w_total_beats;

   assign w_total_beats = BeatW'(({1'b0, ctrl_xfer_size_in_bytes} +
                                  (BeatW + 1)'(BytesPerBeat - 1)) >> LogBpb);

   // awvalid/awlen derive from registers that only move on an AW handshake, so they stay stable.
   assign w_run     = (r_state == StRun);
   assign w_awvalid = w_run && (r_aw_beats_left != '0) &&
                      (r_outstanding < OutW'(C_MAX_OUTSTANDING));
   assign w_awlen   = (r_aw_beats_left >= BeatW'(C_BURST_LEN)) ? 8'(C_BURST_LEN - 1) :
                                                                 8'(r_aw_beats_left - BeatW'(1));
   assign w_awbeats = {1'b0, w_awlen} + 9'd1;

   // W may only run inside bursts whose AW has already been accepted.
   assign w_permit  = w_run && (r_aw_issued != r_w_done);
   // Every burst is full-length except possibly the final one, which ends on the last beat.
   assign w_wlast   = (r_w_beat_cnt == CntW'(C_BURST_LEN - 1)) ||
                      (r_w_beats_left == BeatW'(1));

   assign w_aw_hs   = w_awvalid && m_axi_awready;
   assign w_w_hs    = w_permit && s_axis_tvalid && m_axi_wready;
   assign w_b_hs    = m_axi_bvalid && r_bready;

   assign m_axi_awvalid = w_awvalid;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awlen   = w_awlen;
   assign m_axi_wvalid  = s_axis_tvalid && w_permit;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = w_wlast;
   assign m_axi_bready  = r_bready;
   assign s_axis_tready = m_axi_wready && w_permit;
   assign ctrl_done     = r_done;
`ifdef WR_ERR_CHECK_EN
   assign ctrl_error    = r_error;
`endif

   always_comb begin
      w_state_nxt         = r_state;
      w_awaddr_nxt        = r_awaddr;
      w_aw_beats_left_nxt = r_aw_beats_left;
      w_w_beats_left_nxt  = r_w_beats_left;
      w_aw_issued_nxt     = r_aw_issued;
      w_w_done_nxt        = r_w_done;
      w_w_beat_cnt_nxt    = r_w_beat_cnt;
      w_outstanding_nxt   = r_outstanding;
      w_done_nxt          = (r_state == StDone);
`ifdef WR_ERR_CHECK_EN
      w_error_nxt         = r_error;
`endif

      case (r_state)
         StIdle: begin
            if (ctrl_start) begin
               w_awaddr_nxt        = ctrl_addr_offset & AddrMask;
               w_aw_beats_left_nxt = w_total_beats;
               w_w_beats_left_nxt  = w_total_beats;
               w_aw_issued_nxt     = '0;
               w_w_done_nxt        = '0;
               w_w_beat_cnt_nxt    = '0;
               w_state_nxt         = (w_total_beats == '0) ? StDone : StRun;
`ifdef WR_ERR_CHECK_EN
               w_error_nxt         = 1'b0;
`endif
            end
         end
         StRun: begin
            if (w_aw_hs) begin
               w_awaddr_nxt        = r_awaddr + (C_M_AXI_ADDR_WIDTH'(w_awbeats) << LogBpb);
               w_aw_beats_left_nxt = r_aw_beats_left - BeatW'(w_awbeats);
               w_aw_issued_nxt     = r_aw_issued + BeatW'(1);
            end
            if (w_w_hs) begin
               w_w_beats_left_nxt = r_w_beats_left - BeatW'(1);
               if (w_wlast) begin
                  w_w_beat_cnt_nxt = '0;
                  w_w_done_nxt     = r_w_done + BeatW'(1);
               end else begin
                  w_w_beat_cnt_nxt = r_w_beat_cnt + CntW'(1);
               end
            end
            // All bursts requested and none outstanding means every B has come back.
            if ((r_aw_beats_left == '0) && (r_outstanding == '0)) begin
               w_state_nxt = StDone;
            end
         end
         StDone: w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase

      if (w_aw_hs && !w_b_hs) begin
         w_outstanding_nxt = r_outstanding + OutW'(1);
      end else if (!w_aw_hs && w_b_hs && (r_outstanding != '0)) begin
         w_outstanding_nxt = r_outstanding - OutW'(1);
      end

`ifdef WR_ERR_CHECK_EN
      if (w_b_hs && (m_axi_bresp != 2'b00)) begin
         w_error_nxt = 1'b1;
      end
`endif
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state         <= StIdle;
         r_awaddr        <= '0;
         r_aw_beats_left <= '0;
         r_w_beats_left  <= '0;
         r_aw_issued     <= '0;
         r_w_done        <= '0;
         r_w_beat_cnt    <= '0;
         r_outstanding   <= '0;
         r_done          <= 1'b0;
         r_bready        <= 1'b0;
`ifdef WR_ERR_CHECK_EN
         r_error         <= 1'b0;
`endif
      end else begin
         r_state         <= w_state_nxt;
         r_awaddr        <= w_awaddr_nxt;
         r_aw_beats_left <= w_aw_beats_left_nxt;
         r_w_beats_left  <= w_w_beats_left_nxt;
         r_aw_issued     <= w_aw_issued_nxt;
         r_w_done        <= w_w_done_nxt;
         r_w_beat_cnt    <= w_w_beat_cnt_nxt;
         r_outstanding   <= w_outstanding_nxt;
         r_done          <= w_done_nxt;
         r_bready        <= 1'b1;
`ifdef WR_ERR_CHECK_EN
         r_error         <= w_error_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rtl_kernel_wizard_0_example_axi_write_master.sv
// Scoreboard bench for the AXI write master: expected AW/W beats queued at start, checked on handshake.
// Exercises the WR_ERR_CHECK_EN error path only when that macro is defined.
module tb_rtl_kernel_wizard_0_example_axi_write_master;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int XW = 32;
   localparam int BL = 16;
   localparam int MO = 2;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ctrl_start;
   logic              ctrl_done;
   logic [AW-1:0]     ctrl_addr_offset;
   logic [XW-1:0]     ctrl_xfer_size_in_bytes;
   logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic              tvalid, tready;
   logic [AW-1:0]     awaddr;
   logic [7:0]        awlen;
   logic [DW-1:0]     wdata, tdata;
   logic [DW/8-1:0]   wstrb;
`ifdef WR_ERR_CHECK_EN
   logic [1:0]        bresp;
   logic              ctrl_error;
`endif

   always #5 clk = ~clk;

   rtl_kernel_wizard_0_example_axi_write_master #(
      .C_M_AXI_ADDR_WIDTH (AW),
      .C_M_AXI_DATA_WIDTH (DW),
      .C_XFER_SIZE_WIDTH  (XW),
      .C_BURST_LEN        (BL),
      .C_MAX_OUTSTANDING  (MO)
   ) u_dut (
      .aclk                    (clk),
      .aresetn                 (rst_n),
      .ctrl_start              (ctrl_start),
      .ctrl_done               (ctrl_done),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
`ifdef WR_ERR_CHECK_EN
      .ctrl_error              (ctrl_error),
      .m_axi_bresp             (bresp),
`endif
      .m_axi_awvalid           (awvalid),
      .m_axi_awready           (awready),
      .m_axi_awaddr            (awaddr),
      .m_axi_awlen             (awlen),
      .m_axi_wvalid            (wvalid),
      .m_axi_wready            (wready),
      .m_axi_wdata             (wdata),
      .m_axi_wstrb             (wstrb),
      .m_axi_wlast             (wlast),
      .m_axi_bvalid            (bvalid),
      .m_axi_bready            (bready),
      .s_axis_tvalid           (tvalid),
      .s_axis_tready           (tready),
      .s_axis_tdata            (tdata)
   );

   logic [AW+7:0] exp_aw[$];
   logic [DW:0]   exp_w[$];
   logic [AW+7:0] e_aw;
   logic [DW:0]   e_w;

   int n_vec = 0;
   int n_err = 0;
   int src_idx = 0, tid = 0, b_pending = 0;
   int n_aw = 0, n_b = 0, n_done = 0, n_tready = 0, n_awv = 0;
   int err_at = -1;
   bit rnd = 1'b0, bhold = 1'b0, src_en = 1'b1;
   logic last_err = 1'b0;

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int t, input int i);
      logic [31:0] w;
      w = {t[15:0], i[15:0]};
      return {(DW / 32){w}};
   endfunction

   // Monitor: handshakes are sampled on the falling edge, half a cycle before they take effect.
   always @(negedge clk) begin
      if (awvalid && awready) begin
         n_aw++;
         if (exp_aw.size() == 0) begin
            check_eq("aw_unexpected", DW'(exp_aw.size()), DW'(1));
         end else begin
            e_aw = exp_aw.pop_front();
            check_eq("awaddr", DW'(awaddr), DW'(e_aw[AW+7:8]));
            check_eq("awlen", DW'(awlen), DW'(e_aw[7:0]));
         end
      end
      if (wvalid && wready) begin
         if (exp_w.size() == 0) begin
            check_eq("w_unexpected", DW'(exp_w.size()), DW'(1));
         end else begin
            e_w = exp_w.pop_front();
            check_eq("wdata", wdata, e_w[DW-1:0]);
            check_eq("wlast", DW'(wlast), DW'(e_w[DW]));
            check_eq("wstrb", DW'(wstrb), DW'({(DW/8){1'b1}}));
         end
         if (wlast) b_pending++;
      end
      if (tvalid && tready) src_idx++;
      if (bvalid && bready) begin
         b_pending--;
         n_b++;
      end
      if (ctrl_done) n_done++;
      if (tready) n_tready++;
      if (awvalid) n_awv++;
   end

   // Slave and stream source.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd) begin
            awready = ($urandom_range(0, 3) != 0);
            wready  = ($urandom_range(0, 2) != 0);
            tvalid  = src_en && ($urandom_range(0, 2) != 0);
            bvalid  = (b_pending > 0) && !bhold && ($urandom_range(0, 1) != 0);
         end else begin
            awready = 1'b1;
            wready  = 1'b1;
            tvalid  = src_en;
            bvalid  = (b_pending > 0) && !bhold;
         end
         tdata = pat(tid, src_idx);
`ifdef WR_ERR_CHECK_EN
         bresp = (n_b == err_at) ? 2'b10 : 2'b00;
`endif
      end
   end

   task automatic start_xfer(input logic [AW-1:0] addr, input int size);
      int total, nb;
      logic [AW-1:0] base;
      total = (size + SW - 1) / SW;
      base  = addr & ~AW'(SW - 1);
      tid++;
      src_idx = 0;
      for (int k = 0; k * BL < total; k++) begin
         nb = total - k * BL;
         if (nb > BL) nb = BL;
         exp_aw.push_back({base + AW'(k * BL * SW), 8'(nb - 1)});
      end
      for (int i = 0; i < total; i++) begin
         exp_w.push_back({((i % BL) == BL - 1) || (i == total - 1), pat(tid, i)});
      end
      ctrl_addr_offset        = addr;
      ctrl_xfer_size_in_bytes = XW'(size);
      ctrl_start              = 1'b1;
      @(posedge clk);
      #1;
      ctrl_start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      bit got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 3000 && !got; c++) begin
         @(negedge clk);
         if (ctrl_done) begin
            got = 1'b1;
            lat = c;
`ifdef WR_ERR_CHECK_EN
            last_err = ctrl_error;
`endif
         end
      end
      check_eq("done_seen", DW'(got), DW'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic run_xfer(input logic [AW-1:0] addr, input int size, output int lat);
      start_xfer(addr, size);
      wait_done(lat);
   endtask

   task automatic post_checks(input int done_base);
      repeat (3) @(posedge clk);
      #1;
      check_eq("aw_drained", DW'(exp_aw.size()), DW'(0));
      check_eq("w_drained", DW'(exp_w.size()), DW'(0));
      check_eq("done_pulses", DW'(n_done - done_base), DW'(1));
   endtask

   initial begin
      int lat, d0, t0, a0, v0;
      rst_n = 1'b0;
      ctrl_start = 1'b0;
      ctrl_addr_offset = '0;
      ctrl_xfer_size_in_bytes = '0;
      awready = 1'b0;
      wready = 1'b0;
      bvalid = 1'b0;
      tvalid = 1'b0;
      tdata = '0;
`ifdef WR_ERR_CHECK_EN
      bresp = 2'b00;
`endif
      #3;
      check_eq("rst_awvalid", DW'(awvalid), DW'(0));
      check_eq("rst_wvalid", DW'(wvalid), DW'(0));
      check_eq("rst_tready", DW'(tready), DW'(0));
      check_eq("rst_bready", DW'(bready), DW'(0));
      check_eq("rst_done", DW'(ctrl_done), DW'(0));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bready_run", DW'(bready), DW'(1));

      // Single full burst.
      d0 = n_done;
      run_xfer(64'h1000, 1024, lat);
      post_checks(d0);

      // Zero-size transfer.
      d0 = n_done;
      t0 = n_tready;
      run_xfer(64'h0, 0, lat);
      check_eq("zero_latency", DW'(lat), DW'(2));
      check_eq("zero_tready", DW'(n_tready - t0), DW'(0));
      post_checks(d0);

      // Three bursts with a short tail.
      d0 = n_done;
      run_xfer(64'h2000, 40 * 64, lat);
      post_checks(d0);

      // Unaligned address, two beats, surplus stream beat must stay unconsumed.
      d0 = n_done;
      run_xfer(64'h103F, 65, lat);
      t0 = n_tready;
      post_checks(d0);
      check_eq("src_consumed", DW'(src_idx), DW'(2));
      check_eq("tready_after", DW'(n_tready - t0), DW'(0));

      // Outstanding limit while B is withheld.
      d0 = n_done;
      a0 = n_aw;
      bhold = 1'b1;
      start_xfer(64'h4000, 64 * 64);
      repeat (60) @(posedge clk);
      #1;
      v0 = n_awv;
      repeat (20) @(posedge clk);
      #1;
      check_eq("aw_limited", DW'(n_aw - a0), DW'(2));
      check_eq("awvalid_held", DW'(n_awv - v0), DW'(0));
      bhold = 1'b0;
      wait_done(lat);
      post_checks(d0);
      check_eq("aw_total", DW'(n_aw - a0), DW'(4));

      // Random backpressure and stream gaps.
      d0 = n_done;
      rnd = 1'b1;
      run_xfer(64'h8000, 50 * 64, lat);
      post_checks(d0);
      rnd = 1'b0;

      // Reset in the middle of a burst.
      start_xfer(64'h1000, 1024);
      repeat (6) @(posedge clk);
      #1;
      check_eq("wvalid_pre_rst", DW'(wvalid), DW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_wvalid", DW'(wvalid), DW'(0));
      check_eq("rst_mid_tready", DW'(tready), DW'(0));
      check_eq("rst_mid_awvalid", DW'(awvalid), DW'(0));
      check_eq("rst_mid_bready", DW'(bready), DW'(0));
      exp_aw.delete();
      exp_w.delete();
      b_pending = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      d0 = n_done;
      run_xfer(64'h3000, 64, lat);
      post_checks(d0);

`ifdef WR_ERR_CHECK_EN
      d0 = n_done;
      err_at = n_b;
      run_xfer(64'h5000, 2048, lat);
      check_eq("err_flag", DW'(last_err), DW'(1));
      post_checks(d0);
      err_at = -1;
      d0 = n_done;
      run_xfer(64'h6000, 64, lat);
      check_eq("err_cleared", DW'(last_err), DW'(0));
      post_checks(d0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
